// File: rtl/mux21_feed_arb.sv
// Registered feed stage for mux21_gate: round-robin arbitration between two
// single-bit sources with a bounded burst length and a valid/ready output slot.
module mux21_feed_arb #(
  parameter int unsigned HOLD = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_A,
  input  logic REQ_B,
  input  logic DATA_A,
  input  logic DATA_B,
  input  logic READY,
  output logic A,
  output logic B,
  output logic SEL,
  output logic VALID,
  output logic GNT_A,
  output logic GNT_B
);

  if (HOLD < 1 || HOLD > 15) begin : g_hold_range
    $error("mux21_feed_arb: HOLD must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic       SRC_A    = 1'b0;
  localparam logic       SRC_B    = 1'b1;
  localparam logic [3:0] HOLD_CNT = 4'(HOLD);
  localparam logic [3:0] CNT_MAX  = 4'd15;

  state_t     state;
  logic       last;
  logic [3:0] cnt;

  logic       slot_free;
  logic       grant_any;
  logic       grant_src;
  logic       same_owner;
  logic [3:0] cnt_next;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    slot_free = !VALID || READY;
    grant_any = REQ_A || REQ_B;
    grant_src = SRC_A;

    if (REQ_A && !REQ_B) begin
      grant_src = SRC_A;
    end else if (REQ_B && !REQ_A) begin
      grant_src = SRC_B;
    end else if (REQ_A && REQ_B) begin
      // The burst limit only matters while both sources compete.
      unique case (state)
        OWN_A:   grant_src = (cnt < HOLD_CNT) ? SRC_A : SRC_B;
        OWN_B:   grant_src = (cnt < HOLD_CNT) ? SRC_B : SRC_A;
        default: grant_src = !last;
      endcase
    end

    same_owner = (state == OWN_A && grant_src == SRC_A) ||
                 (state == OWN_B && grant_src == SRC_B);
    cnt_next   = 4'd1;
    if (same_owner) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
    end
  end

  assign GNT_A = slot_free && grant_any && (grant_src == SRC_A) && !RST;
  assign GNT_B = slot_free && grant_any && (grant_src == SRC_B) && !RST;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      A     <= 1'b0;
      B     <= 1'b0;
      SEL   <= 1'b0;
      VALID <= 1'b0;
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= SRC_B;
    end else if (slot_free) begin
      if (grant_any) begin
        A     <= DATA_A;
        B     <= DATA_B;
        SEL   <= grant_src;
        VALID <= 1'b1;
        state <= (grant_src == SRC_B) ? OWN_B : OWN_A;
        last  <= grant_src;
        cnt   <= cnt_next;
      end else begin
        VALID <= 1'b0;
        state <= IDLE;
        cnt   <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_mux21_feed_arb.sv
// Directed bench for mux21_feed_arb: stimulus pushes hand-derived transfers into
// a scoreboard queue, a monitor pops them whenever the output is accepted.
module tb_mux21_feed_arb;

  logic clk;
  logic rst;
  logic req_a, req_b, data_a, data_b, ready;
  logic a, b, sel, valid, gnt_a, gnt_b;

  int errors = 0;
  int checks = 0;

  // Expected transfer: {A, B, SEL}
  logic [2:0] sb[$];

  mux21_feed_arb #(.HOLD(4)) dut (
    .CLK   (clk),
    .RST   (rst),
    .REQ_A (req_a),
    .REQ_B (req_b),
    .DATA_A(data_a),
    .DATA_B(data_b),
    .READY (ready),
    .A     (a),
    .B     (b),
    .SEL   (sel),
    .VALID (valid),
    .GNT_A (gnt_a),
    .GNT_B (gnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check grants (and optionally the registered
  // outputs from the previous edge) at the falling edge, then cross the edge.
  task automatic cyc(input logic r, input logic ra, input logic rb,
                     input logic da, input logic db, input logic rdy,
                     input logic ega, input logic egb,
                     input bit chk = 1'b0, input logic ev = 1'b0,
                     input logic es = 1'b0, input logic ea = 1'b0,
                     input logic eb = 1'b0);
    rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db; ready = rdy;
    @(negedge clk);
    check("gnt_a", int'(gnt_a), int'(ega));
    check("gnt_b", int'(gnt_b), int'(egb));
    if (chk) begin
      check("valid", int'(valid), int'(ev));
      check("sel",   int'(sel),   int'(es));
      check("a",     int'(a),     int'(ea));
      check("b",     int'(b),     int'(eb));
    end
    if (ega || egb) sb.push_back({da, db, egb});
    @(posedge clk);
    if (r) sb.delete();
    #1;
  endtask

  // Monitor: compare every accepted transfer against the scoreboard head.
  initial begin
    logic [2:0] exp_t;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && ready === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL xfer at %0t: got unexpected {a,b,sel}=%b expected none",
                   $time, {a, b, sel});
        end else begin
          exp_t = sb.pop_front();
          check("xfer", int'({a, b, sel}), int'(exp_t));
        end
      end
    end
  end

  initial begin
    // Reset with both sources requesting: no grants, outputs cleared.
    cyc(1, 1, 1, 1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0);

    // Fairness with HOLD=4: four A grants, four B grants, repeated.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      logic       own_a;
      iv    = 4'(i);
      own_a = ((i / 4) % 2) == 0;
      cyc(0, 1, 1, iv[0], iv[1], 1, own_a, !own_a);
    end

    // Lone requester A, 18 grants: HOLD ignored, counter saturates at 15.
    for (int i = 0; i < 18; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      cyc(0, 1, 0, iv[0], 1, 1, 1, 0);
    end

    // Both request after the long A run: saturated count forces B.
    cyc(0, 1, 1, 1, 0, 1, 0, 1);

    // Backpressure: slot frozen holding A=1,B=0,SEL=1.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0);
    // Release: transfer completes and B (burst count 1) loads at the same edge.
    cyc(0, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 0);

    // Idle two cycles: VALID drops, SEL holds 1.
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1);

    // Resume with both: A by the not-last rule, fresh burst of four, then B.
    cyc(0, 1, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1);
    cyc(0, 1, 1, 1, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0, 1, 0, 1);

    // Stall, then reset mid-stall: pending transfer discarded.
    cyc(0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0);
    cyc(1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0);
    // First tie after reset goes to A.
    cyc(0, 1, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0);

    // Drain.
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1);

    check("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
